// File: rtl/unidade_de_busca.sv
// unidade_de_busca: instruction fetch unit between the PC register and decode.
// Reads the word at the current PC over a req/ack handshake, buffers it for
// decode, and pulses pc_avanca so the PC advances only when a fetch completes.
// Redirect flushes discard the buffered and in-flight words; an unanswered
// request faults the block into a sticky error state.
//
// Handshakes:
//   memory side : mem_req/mem_endereco are registered and held stable until
//                 the cycle in which mem_ack=1; mem_dado is sampled only then.
//   decode side : a word transfers in every cycle where instrucao_valida=1
//                 and decod_pronto=1; while decod_pronto=0 the word and its
//                 address are held unchanged and no new request is issued.
module unidade_de_busca #(
    parameter int LARGURA_END  = 26,
    parameter int LARGURA_INST = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LARGURA_END-1:0]  pcAtual,
    input  logic                    flush,
    output logic                    mem_req,
    output logic [LARGURA_END-1:0]  mem_endereco,
    input  logic                    mem_ack,
    input  logic [LARGURA_INST-1:0] mem_dado,
    output logic [LARGURA_INST-1:0] instrucao,
    output logic [LARGURA_END-1:0]  instrucao_pc,
    output logic                    instrucao_valida,
    input  logic                    decod_pronto,
    output logic                    pc_avanca,
    output logic                    erro_busca,
    output logic [1:0]              estado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        DESCARTA = 2'd2,
        ERRO     = 2'd3
    } estado_t;

    // Counter only needs to reach TIMEOUT-1 (the last request cycle).
    localparam int LARGURA_CONT = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LARGURA_CONT-1:0] ULTIMO_CICLO = LARGURA_CONT'(TIMEOUT - 1);

    estado_t                 estado_q;
    logic [LARGURA_CONT-1:0] contador;
    logic                    buffer_livre;

    // Buffer is free when empty or when decode takes the word this cycle.
    assign buffer_livre = !instrucao_valida || decod_pronto;

    // Current FSM state exposed for observation.
    assign estado = estado_q;

    // Fetch FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q         <= OCIOSO;
            mem_req          <= 1'b0;
            mem_endereco     <= '0;
            instrucao        <= '0;
            instrucao_pc     <= '0;
            instrucao_valida <= 1'b0;
            pc_avanca        <= 1'b0;
            erro_busca       <= 1'b0;
            contador         <= '0;
        end else begin
            pc_avanca <= 1'b0;

            // Flush beats consumption; a load below overrides both.
            if (estado_q != ERRO) begin
                if (flush) begin
                    instrucao_valida <= 1'b0;
                end else if (instrucao_valida && decod_pronto) begin
                    instrucao_valida <= 1'b0;
                end
            end

            case (estado_q)
                OCIOSO: begin
                    if (!flush && buffer_livre) begin
                        mem_endereco <= pcAtual;
                        mem_req      <= 1'b1;
                        contador     <= '0;
                        estado_q     <= ESPERA;
                    end
                end

                ESPERA: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        estado_q <= OCIOSO;
                        if (!flush) begin
                            instrucao        <= mem_dado;
                            instrucao_pc     <= mem_endereco;
                            instrucao_valida <= 1'b1;
                            pc_avanca        <= 1'b1;
                        end
                    end else if (contador == ULTIMO_CICLO) begin
                        mem_req          <= 1'b0;
                        erro_busca       <= 1'b1;
                        instrucao_valida <= 1'b0;
                        estado_q         <= ERRO;
                    end else begin
                        contador <= contador + 1'b1;
                        // Request stays up; its answer will be thrown away.
                        if (flush) begin
                            estado_q <= DESCARTA;
                        end
                    end
                end

                DESCARTA: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        estado_q <= OCIOSO;
                    end else if (contador == ULTIMO_CICLO) begin
                        mem_req          <= 1'b0;
                        erro_busca       <= 1'b1;
                        instrucao_valida <= 1'b0;
                        estado_q         <= ERRO;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end

                ERRO: begin
                    // Sticky until reset.
                    estado_q <= ERRO;
                end

                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench for unidade_de_busca (TIMEOUT=4 so the fault path is short).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_unidade_de_busca;

    localparam int LE = 26;
    localparam int LI = 32;

    localparam logic [1:0] S_OCIOSO   = 2'd0;
    localparam logic [1:0] S_ESPERA   = 2'd1;
    localparam logic [1:0] S_DESCARTA = 2'd2;
    localparam logic [1:0] S_ERRO     = 2'd3;

    logic          clock;
    logic          reset;
    logic [LE-1:0] pcAtual;
    logic          flush;
    logic          mem_req;
    logic [LE-1:0] mem_endereco;
    logic          mem_ack;
    logic [LI-1:0] mem_dado;
    logic [LI-1:0] instrucao;
    logic [LE-1:0] instrucao_pc;
    logic          instrucao_valida;
    logic          decod_pronto;
    logic          pc_avanca;
    logic          erro_busca;
    logic [1:0]    estado;

    int n_vec = 0;
    int n_err = 0;
    int n_hi;

    unidade_de_busca #(
        .LARGURA_END (LE),
        .LARGURA_INST(LI),
        .TIMEOUT     (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pcAtual         (pcAtual),
        .flush           (flush),
        .mem_req         (mem_req),
        .mem_endereco    (mem_endereco),
        .mem_ack         (mem_ack),
        .mem_dado        (mem_dado),
        .instrucao       (instrucao),
        .instrucao_pc    (instrucao_pc),
        .instrucao_valida(instrucao_valida),
        .decod_pronto    (decod_pronto),
        .pc_avanca       (pc_avanca),
        .erro_busca      (erro_busca),
        .estado          (estado)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_estado"}, 64'(estado), 64'(S_OCIOSO));
        check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check({tag, "_mem_endereco"}, 64'(mem_endereco), 64'd0);
        check({tag, "_instrucao"}, 64'(instrucao), 64'd0);
        check({tag, "_instrucao_pc"}, 64'(instrucao_pc), 64'd0);
        check({tag, "_valida"}, 64'(instrucao_valida), 64'd0);
        check({tag, "_pc_avanca"}, 64'(pc_avanca), 64'd0);
        check({tag, "_erro"}, 64'(erro_busca), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        pcAtual      = 26'h0000100;
        flush        = 1'b0;
        mem_ack      = 1'b0;
        mem_dado     = '0;
        decod_pronto = 1'b1;
        tick();
        tick();
        check_reset_values("reset");

        // First fetch: request one cycle after reset release, ack at once.
        reset = 1'b0;
        tick();
        check("req1_mem_req", 64'(mem_req), 64'd1);
        check("req1_addr", 64'(mem_endereco), 64'h100);
        check("req1_estado", 64'(estado), 64'(S_ESPERA));
        mem_ack      = 1'b1;
        mem_dado     = 32'h8C220004;
        decod_pronto = 1'b0;
        tick();
        check("del1_instrucao", 64'(instrucao), 64'h8C220004);
        check("del1_pc", 64'(instrucao_pc), 64'h100);
        check("del1_valida", 64'(instrucao_valida), 64'd1);
        check("del1_pc_avanca", 64'(pc_avanca), 64'd1);
        check("del1_mem_req", 64'(mem_req), 64'd0);
        mem_ack  = 1'b0;
        mem_dado = 32'hFFFFFFFF;
        pcAtual  = 26'h0000104;

        // Backpressure: five cycles with decode stalled.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_mem_req", 64'(mem_req), 64'd0);
            check("bp_instrucao", 64'(instrucao), 64'h8C220004);
            check("bp_pc", 64'(instrucao_pc), 64'h100);
            check("bp_valida", 64'(instrucao_valida), 64'd1);
            check("bp_pc_avanca", 64'(pc_avanca), 64'd0);
        end
        decod_pronto = 1'b1;
        tick();
        check("bp_rel_mem_req", 64'(mem_req), 64'd1);
        check("bp_rel_addr", 64'(mem_endereco), 64'h104);
        check("bp_rel_valida", 64'(instrucao_valida), 64'd0);

        // Flush while waiting, ack three cycles later.
        flush = 1'b1;
        tick();
        check("fl_estado", 64'(estado), 64'(S_DESCARTA));
        check("fl_mem_req", 64'(mem_req), 64'd1);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("fl_hold_req", 64'(mem_req), 64'd1);
            check("fl_hold_addr", 64'(mem_endereco), 64'h104);
            check("fl_hold_pc_avanca", 64'(pc_avanca), 64'd0);
        end
        mem_ack  = 1'b1;
        mem_dado = 32'hDEADBEEF;
        pcAtual  = 26'h0000108;
        tick();
        check("fl_ack_estado", 64'(estado), 64'(S_OCIOSO));
        check("fl_ack_mem_req", 64'(mem_req), 64'd0);
        check("fl_ack_valida", 64'(instrucao_valida), 64'd0);
        check("fl_ack_pc_avanca", 64'(pc_avanca), 64'd0);
        check("fl_ack_instrucao", 64'(instrucao), 64'h8C220004);
        mem_ack = 1'b0;
        tick();
        check("fl_next_req", 64'(mem_req), 64'd1);
        check("fl_next_addr", 64'(mem_endereco), 64'h108);

        // Flush and ack in the same cycle, flush held one more cycle.
        flush    = 1'b1;
        mem_ack  = 1'b1;
        mem_dado = 32'h11111111;
        tick();
        check("flack_estado", 64'(estado), 64'(S_OCIOSO));
        check("flack_valida", 64'(instrucao_valida), 64'd0);
        check("flack_pc_avanca", 64'(pc_avanca), 64'd0);
        check("flack_mem_req", 64'(mem_req), 64'd0);
        mem_ack = 1'b0;
        tick();
        check("flack_hold_req", 64'(mem_req), 64'd0);
        check("flack_hold_estado", 64'(estado), 64'(S_OCIOSO));
        flush = 1'b0;
        tick();
        check("flack_reissue_req", 64'(mem_req), 64'd1);
        check("flack_reissue_addr", 64'(mem_endereco), 64'h108);

        // Back-to-back delivery: one word every two cycles.
        mem_ack  = 1'b1;
        mem_dado = 32'h22222222;
        pcAtual  = 26'h000010C;
        tick();
        check("del2_instrucao", 64'(instrucao), 64'h22222222);
        check("del2_pc", 64'(instrucao_pc), 64'h108);
        check("del2_valida", 64'(instrucao_valida), 64'd1);
        check("del2_pc_avanca", 64'(pc_avanca), 64'd1);
        mem_ack = 1'b0;
        tick();
        check("del2_next_req", 64'(mem_req), 64'd1);
        check("del2_next_addr", 64'(mem_endereco), 64'h10C);
        check("del2_consumed", 64'(instrucao_valida), 64'd0);
        check("del2_pulse_end", 64'(pc_avanca), 64'd0);

        // Timeout: no ack ever; request must stay up exactly 4 cycles.
        n_hi = 0;
        while (mem_req && n_hi < 20) begin
            n_hi++;
            tick();
        end
        check("to_req_cycles", 64'(n_hi), 64'd4);
        check("to_erro", 64'(erro_busca), 64'd1);
        check("to_mem_req", 64'(mem_req), 64'd0);
        check("to_estado", 64'(estado), 64'(S_ERRO));

        // Fault state ignores every input.
        flush        = 1'b1;
        mem_ack      = 1'b1;
        decod_pronto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_hold_erro", 64'(erro_busca), 64'd1);
            check("err_hold_req", 64'(mem_req), 64'd0);
            check("err_hold_estado", 64'(estado), 64'(S_ERRO));
        end
        flush   = 1'b0;
        mem_ack = 1'b0;
        reset   = 1'b1;
        tick();
        check_reset_values("err_reset");

        // Reset in the middle of a pending request.
        reset   = 1'b0;
        pcAtual = 26'h0000200;
        tick();
        check("mid_req", 64'(mem_req), 64'd1);
        mem_ack  = 1'b1;
        mem_dado = 32'h33333333;
        tick();
        check("mid_del", 64'(instrucao), 64'h33333333);
        mem_ack = 1'b0;
        pcAtual = 26'h0000204;
        tick();
        check("mid_req2", 64'(mem_req), 64'd1);
        check("mid_estado", 64'(estado), 64'(S_ESPERA));
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_de_busca.md
# unidade_de_busca

Instruction fetch unit that sits directly downstream of the program counter register. It takes the current PC and issues a read to instruction memory over a req/ack handshake. It buffers the returned word for the decode stage and pulses a PC-advance enable so the counter loads its next address only when a fetch completes. It also handles redirect flushes and memory timeouts.

## Interface
- LARGURA_END, 26, address width; matches the PC width.
- LARGURA_INST, 32, instruction word width.
- TIMEOUT, 255, cycles an outstanding request may wait for ack before the block faults (≥1).

- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pcAtual  in  LARGURA_END  current program counter value.
- flush  in  1  redirect (branch/jump/exception); discard current and in-flight fetch.
- mem_req  out  1  instruction memory read request.
- mem_endereco  out  LARGURA_END  read address; held stable while mem_req=1.
- mem_ack  in  1  memory has returned data on mem_dado this cycle.
- mem_dado  in  LARGURA_INST  read data; sampled only when mem_ack=1.
- instrucao  out  LARGURA_INST  buffered instruction for decode.
- instrucao_pc  out  LARGURA_END  address the buffered instruction came from.
- instrucao_valida  out  1  instrucao/instrucao_pc hold a valid, unconsumed word.
- decod_pronto  in  1  decode accepts the word this cycle when instrucao_valida=1.
- pc_avanca  out  1  one-cycle pulse; PC write enable for the next address.
- erro_busca  out  1  sticky timeout fault.

## Operation
- Reset values: state OCIOSO, mem_req=0, mem_endereco=0, instrucao=0, instrucao_pc=0, instrucao_valida=0, pc_avanca=0, erro_busca=0, timeout counter=0.
- Buffer free: instrucao_valida=0, or instrucao_valida=1 and decod_pronto=1 in the same cycle. When consumed with no new load, instrucao_valida clears at the edge.

- OCIOSO:
  - flush=1: clear instrucao_valida and stay in OCIOSO; no request issues that cycle.
  - Else, if the buffer is free: mem_endereco←pcAtual, mem_req←1, counter←0, go to ESPERA.

- ESPERA:
  - mem_ack=1 and flush=0: instrucao←mem_dado, instrucao_pc←mem_endereco, instrucao_valida←1, pc_avanca←1 for one cycle, mem_req←0, go to OCIOSO.
  - mem_ack=1 and flush=1: drop the data; no valid, no pc_avanca; mem_req←0, go to OCIOSO.
  - flush=1 and mem_ack=0: go to DESCARTA with mem_req still high.
  - Else: counter increments.

- DESCARTA: hold mem_req until mem_ack, drop the data, go to OCIOSO; pc_avanca stays 0.
- flush in any state clears instrucao_valida at that edge; it has priority over consumption and over load.
- Timeout: in ESPERA or DESCARTA, if mem_ack=0 and counter==TIMEOUT-1, go to ERRO. ERRO sets mem_req←0, erro_busca←1 and instrucao_valida←0.
- ERRO is left only by reset; all inputs are ignored there.
- reset has priority over everything and aborts any outstanding request at that edge (mem_req=0 after the edge).

## Timing
- Request rises at the edge after OCIOSO sees a free buffer and no flush.
- With ack in the first request cycle, instrucao_valida and pc_avanca rise at the next edge.
- Best case throughput: one instruction every 2 cycles.
- mem_endereco and mem_req are registered.
- mem_ack may be combinational from mem_req/mem_endereco.
- pc_avanca is high for exactly one cycle per delivered instruction, coincident with instrucao_valida rising. The PC therefore loads its next address on the following edge.
- A word held with decod_pronto=0 blocks new requests, and instrucao/instrucao_pc stay unchanged.
- Ack is honored through the TIMEOUT-th request cycle; the fault asserts at the edge ending that cycle.

## Test plan
- Reset then pcAtual=0x0000100, mem_ack on first request cycle with mem_dado=0x8C220004:
  - mem_req=1 with mem_endereco=0x0000100 one cycle after reset release.
  - Next edge: instrucao=0x8C220004, instrucao_pc=0x0000100, instrucao_valida=1, pc_avanca=1 for one cycle.
- Backpressure: decod_pronto=0 for 5 cycles after a delivery.
  - mem_req stays 0 and the outputs hold.
  - When decod_pronto=1, a new request issues the next edge.
- Flush during ESPERA, ack 3 cycles later with 0xDEADBEEF:
  - mem_req stays high until ack.
  - 0xDEADBEEF is never presented, and pc_avanca stays 0.
- Flush and ack in the same cycle:
  - Data is dropped, instrucao_valida=0, state OCIOSO.
  - A request issues the edge after flush deasserts.
- TIMEOUT=4, mem_ack never asserted:
  - mem_req is high for exactly 4 cycles, then erro_busca=1 and mem_req=0.
  - Inputs are ignored until reset, which clears erro_busca.
- Reset asserted mid-ESPERA: all outputs return to the reset values listed above at that edge.
